// File: rtl/piece_mover.sv
`default_nettype none
// ============================================================================
// Module   : piece_mover
// Purpose  : Chess board state holder. It takes pick/place requests from a
//            cursor decoder, keeps the 8x8 board, tracks the side to move and
//            commits one move at a time through an IDLE/HELD/COMMIT FSM.
// Ports    : clk            - system clock, rising edge
//            rst            - asynchronous active-high reset (restores the
//                             start position)
//            pick_piece     - level; a rising edge requests selection
//            place_piece    - level; a rising edge requests placement
//            mouse_position - [5:3] row, [2:0] column under the cursor
//            board          - registered board, board[row][col], 4-bit codes
//                             (0 empty, 1..6 P N B R Q K, bit3 = black)
//            sel_valid      - a piece is currently held
//            sel_square     - square of the held piece
//            turn           - side to move (0 white, 1 black)
//            move_done      - one-cycle pulse when a move is written
//            move_reject    - one-cycle pulse when a request is refused
// Config   : PIECE_MOVER_TURN_CHECK_EN - when defined, pick and place colour
//            checks are made against turn; otherwise any non-empty square is
//            pickable and a place is refused only onto a same-colour piece.
// Revision : 1.0 - initial release
// ============================================================================
module piece_mover #(
    parameter logic INIT_TURN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pick_piece,
    input  logic       place_piece,
    input  logic [5:0] mouse_position,
    output logic [3:0] board [0:7][0:7],
    output logic       sel_valid,
    output logic [5:0] sel_square,
    output logic       turn,
    output logic       move_done,
    output logic       move_reject
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_pick_prev;
    logic       r_place_prev;
    logic [5:0] r_target;

    logic       w_pick_edge;
    logic       w_place_edge;
    logic [3:0] w_cursor_piece;
    logic [3:0] w_held_piece;
    logic       w_pick_ok;
    logic       w_target_blocked;
    logic       w_do_select;
    logic       w_do_cancel;
    logic       w_do_reject;
    logic       w_do_latch;

    // Start position: back rank piece type by column, colour by row.
    function automatic logic [3:0] start_piece(input logic [2:0] row, input logic [2:0] col);
        logic [2:0] kind;
        case (col)
            3'd0, 3'd7: kind = 3'd4;
            3'd1, 3'd6: kind = 3'd2;
            3'd2, 3'd5: kind = 3'd3;
            3'd3:       kind = 3'd5;
            default:    kind = 3'd6;
        endcase
        case (row)
            3'd0:    start_piece = {1'b1, kind};
            3'd1:    start_piece = 4'd9;
            3'd6:    start_piece = 4'd1;
            3'd7:    start_piece = {1'b0, kind};
            default: start_piece = 4'd0;
        endcase
    endfunction

    assign w_pick_edge    = pick_piece  & ~r_pick_prev;
    assign w_place_edge   = place_piece & ~r_place_prev;
    assign w_cursor_piece = board[mouse_position[5:3]][mouse_position[2:0]];
    assign w_held_piece   = board[sel_square[5:3]][sel_square[2:0]];

`ifdef PIECE_MOVER_TURN_CHECK_EN
    assign w_pick_ok        = (w_cursor_piece != 4'd0) && (w_cursor_piece[3] == turn);
    assign w_target_blocked = (w_cursor_piece != 4'd0) && (w_cursor_piece[3] == turn);
`else
    assign w_pick_ok        = (w_cursor_piece != 4'd0);
    assign w_target_blocked = (w_cursor_piece != 4'd0) && (w_cursor_piece[3] == w_held_piece[3]);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle actions. Only pick edges matter in IDLE and
    // only place edges in HELD, which also settles simultaneous edges.
    always_comb begin
        w_next_state = r_state;
        w_do_select  = 1'b0;
        w_do_cancel  = 1'b0;
        w_do_reject  = 1'b0;
        w_do_latch   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_edge) begin
                    if (w_pick_ok) begin
                        w_do_select  = 1'b1;
                        w_next_state = HELD;
                    end else begin
                        w_do_reject  = 1'b1;
                    end
                end
            end
            HELD: begin
                if (w_place_edge) begin
                    if (mouse_position == sel_square) begin
                        w_do_cancel  = 1'b1;
                        w_next_state = IDLE;
                    end else if (w_target_blocked) begin
                        w_do_reject  = 1'b1;
                    end else begin
                        w_do_latch   = 1'b1;
                        w_next_state = COMMIT;
                    end
                end
            end
            COMMIT: begin
                // Single write cycle; any edge seen here is dropped.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: edge history, selection, board and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pick_prev  <= 1'b0;
            r_place_prev <= 1'b0;
            r_target     <= 6'd0;
            sel_valid    <= 1'b0;
            sel_square   <= 6'd0;
            turn         <= INIT_TURN;
            move_done    <= 1'b0;
            move_reject  <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    board[r][c] <= start_piece(3'(r), 3'(c));
                end
            end
        end else begin
            r_pick_prev  <= pick_piece;
            r_place_prev <= place_piece;
            move_reject  <= w_do_reject;
            move_done    <= (r_state == COMMIT);

            if (w_do_select) begin
                sel_square <= mouse_position;
                sel_valid  <= 1'b1;
            end
            if (w_do_cancel) begin
                sel_valid  <= 1'b0;
            end
            if (w_do_latch) begin
                r_target   <= mouse_position;
            end

            // Target and source never coincide here (equal squares cancel).
            if (r_state == COMMIT) begin
                board[r_target[5:3]][r_target[2:0]]     <= w_held_piece;
                board[sel_square[5:3]][sel_square[2:0]] <= 4'd0;
                turn      <= ~turn;
                sel_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piece_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_mover
// Purpose  : Self-checking bench for piece_mover. A square-indexed board model
//            applies the pick/place rules directly and is compared against
//            the DUT after directed scenarios and a randomized move sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piece_mover;

`ifdef PIECE_MOVER_TURN_CHECK_EN
    localparam bit TURN_CHECK = 1'b1;
`else
    localparam bit TURN_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pick_piece = 1'b0;
    logic       place_piece = 1'b0;
    logic [5:0] mouse_position = 6'd0;
    logic [3:0] board [0:7][0:7];
    logic       sel_valid;
    logic [5:0] sel_square;
    logic       turn;
    logic       move_done;
    logic       move_reject;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: flat 64-entry board plus selection and side to move.
    logic [3:0] mb [0:63];
    logic       mturn;
    logic       mheld;
    logic [5:0] msel;

    piece_mover #(.INIT_TURN(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .pick_piece     (pick_piece),
        .place_piece    (place_piece),
        .mouse_position (mouse_position),
        .board          (board),
        .sel_valid      (sel_valid),
        .sel_square     (sel_square),
        .turn           (turn),
        .move_done      (move_done),
        .move_reject    (move_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        int back [0:7];
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int i = 0; i < 64; i++) mb[i] = 4'd0;
        for (int c = 0; c < 8; c++) begin
            mb[c]      = 4'(back[c] + 8);
            mb[8 + c]  = 4'd9;
            mb[48 + c] = 4'd1;
            mb[56 + c] = 4'(back[c]);
        end
        mturn = 1'b0;
        mheld = 1'b0;
        msel  = 6'd0;
    endfunction

    function automatic void model_move(input int from, input int to);
        mb[to]   = mb[from];
        mb[from] = 4'd0;
        mturn    = ~mturn;
        mheld    = 1'b0;
    endfunction

    function automatic bit model_pick_ok(input int sq);
        if (mb[sq] == 4'd0) return 1'b0;
        if (TURN_CHECK) return (mb[sq][3] == mturn);
        return 1'b1;
    endfunction

    // 0 = cancel, 1 = refused, 2 = move
    function automatic int model_place_kind(input int t);
        logic own;
        if (t == int'(msel)) return 0;
        own = TURN_CHECK ? mturn : mb[msel][3];
        if (mb[t] != 4'd0 && mb[t][3] == own) return 1;
        return 2;
    endfunction

    function automatic int board_first_diff();
        for (int i = 0; i < 64; i++)
            if (board[i / 8][i % 8] !== mb[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one rising edge; returns at the sample point one cycle later.
    task automatic raise_pick(input int sq);
        mouse_position = 6'(sq);
        pick_piece = 1'b1;
        tick();
        pick_piece = 1'b0;
    endtask

    task automatic raise_place(input int sq);
        mouse_position = 6'(sq);
        place_piece = 1'b1;
        tick();
        place_piece = 1'b0;
    endtask

    task automatic drive_move(input int from, input int to);
        raise_pick(from);
        tick();
        raise_place(to);
        tick();
        tick();
        model_move(from, to);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        d = board_first_diff();
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL reset_board: square %0d is %0d, expected %0d", d, board[d / 8][d % 8], mb[d]);
        end
        tests_run++;
        if (sel_valid !== 1'b0 || sel_square !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_sel: sel_valid=%b sel_square=%0d, expected 0/0", sel_valid, sel_square);
        end
        tests_run++;
        if (turn !== 1'b0 || move_done !== 1'b0 || move_reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: turn=%b done=%b reject=%b, expected 0/0/0", turn, move_done, move_reject);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reject_pick();
        raise_pick(27);
        tests_run++;
        if (move_reject !== 1'b1 || sel_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_pick: reject=%b sel_valid=%b, expected 1/0", move_reject, sel_valid);
        end
        tick();
        tests_run++;
        if (move_reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_pulse_width: reject=%b, expected 0", move_reject);
        end
`ifdef PIECE_MOVER_TURN_CHECK_EN
        raise_pick(8);
        tests_run++;
        if (move_reject !== 1'b1 || sel_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrong_colour_pick: reject=%b sel_valid=%b, expected 1/0", move_reject, sel_valid);
        end
        tick();
`endif
    endtask

    task automatic test_cancel();
        raise_pick(52);
        tests_run++;
        if (sel_valid !== 1'b1 || sel_square !== 6'd52) begin
            tests_failed++;
            $display("FAIL pick_52: sel_valid=%b sel_square=%0d, expected 1/52", sel_valid, sel_square);
        end
        tick();
        raise_place(52);
        tests_run++;
        if (sel_valid !== 1'b0 || move_reject !== 1'b0 || move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel: sel_valid=%b reject=%b done=%b, expected 0/0/0", sel_valid, move_reject, move_done);
        end
        tick();
        tests_run++;
        if (move_done !== 1'b0 || board_first_diff() >= 0) begin
            tests_failed++;
            $display("FAIL cancel_board: done=%b first_diff=%0d, expected 0/-1", move_done, board_first_diff());
        end
        tick();
    endtask

    task automatic test_blocked_place();
        raise_pick(52);
        tick();
        raise_place(60);
        tests_run++;
        if (move_reject !== 1'b1 || sel_valid !== 1'b1 || sel_square !== 6'd52) begin
            tests_failed++;
            $display("FAIL blocked_place: reject=%b sel_valid=%b sel=%0d, expected 1/1/52", move_reject, sel_valid, sel_square);
        end
        tick();
        raise_place(36);
        tests_run++;
        if (move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL commit_early: done=%b one cycle after edge, expected 0", move_done);
        end
        tick();
        model_move(52, 36);
        tests_run++;
        if (board[4][4] !== 4'd1 || board[6][4] !== 4'd0 || board_first_diff() >= 0) begin
            tests_failed++;
            $display("FAIL opening_board: b44=%0d b64=%0d first_diff=%0d, expected 1/0/-1", board[4][4], board[6][4], board_first_diff());
        end
        tests_run++;
        if (move_done !== 1'b1 || turn !== 1'b1 || sel_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL opening_status: done=%b turn=%b sel_valid=%b, expected 1/1/0", move_done, turn, sel_valid);
        end
        tick();
        tests_run++;
        if (move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width: done=%b, expected 0", move_done);
        end
    endtask

    task automatic test_capture();
        apply_reset();
        drive_move(53, 45);
        drive_move(12, 28);
        drive_move(48, 40);
        drive_move(28, 36);
        raise_pick(45);
        tick();
        raise_place(36);
        tick();
        model_move(45, 36);
        tests_run++;
        if (board[4][4] !== 4'd1 || board[5][5] !== 4'd0 || move_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL capture: b44=%0d b55=%0d done=%b, expected 1/0/1", board[4][4], board[5][5], move_done);
        end
        tests_run++;
        if (board_first_diff() >= 0 || turn !== mturn) begin
            tests_failed++;
            $display("FAIL capture_state: first_diff=%0d turn=%b, expected -1/%b", board_first_diff(), turn, mturn);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // Simultaneous edges in IDLE: only the pick counts.
        mouse_position = 6'd52;
        pick_piece = 1'b1;
        place_piece = 1'b1;
        tick();
        tests_run++;
        if (sel_valid !== 1'b1 || sel_square !== 6'd52 || move_done !== 1'b0 || move_reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_edges_idle: sel_valid=%b sel=%0d done=%b reject=%b, expected 1/52/0/0", sel_valid, sel_square, move_done, move_reject);
        end
        pick_piece = 1'b0;
        place_piece = 1'b0;
        tick();
        // Simultaneous edges in HELD: only the place counts.
        mouse_position = 6'd44;
        pick_piece = 1'b1;
        place_piece = 1'b1;
        tick();
        pick_piece = 1'b0;
        place_piece = 1'b0;
        tick();
        model_move(52, 44);
        tests_run++;
        if (move_done !== 1'b1 || board_first_diff() >= 0 || turn !== mturn) begin
            tests_failed++;
            $display("FAIL both_edges_held: done=%b first_diff=%0d turn=%b, expected 1/-1/%b", move_done, board_first_diff(), turn, mturn);
        end
        tick();
        // A pick edge during COMMIT is dropped.
        raise_pick(12);
        tick();
        raise_place(28);
        mouse_position = 6'd49;
        pick_piece = 1'b1;
        tick();
        model_move(12, 28);
        tests_run++;
        if (move_done !== 1'b1 || board_first_diff() >= 0) begin
            tests_failed++;
            $display("FAIL commit_black: done=%b first_diff=%0d, expected 1/-1", move_done, board_first_diff());
        end
        tick();
        tests_run++;
        if (sel_valid !== 1'b0 || move_reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_in_commit: sel_valid=%b reject=%b, expected 0/0", sel_valid, move_reject);
        end
        pick_piece = 1'b0;
        tick();
        // A pick edge in the move_done cycle is accepted.
        raise_pick(49);
        tick();
        raise_place(41);
        tick();
        model_move(49, 41);
        mouse_position = 6'd13;
        pick_piece = 1'b1;
        tick();
        pick_piece = 1'b0;
        tests_run++;
        if (sel_valid !== 1'b1 || sel_square !== 6'd13) begin
            tests_failed++;
            $display("FAIL pick_after_commit: sel_valid=%b sel=%0d, expected 1/13", sel_valid, sel_square);
        end
        tick();
        raise_place(13);
        tick();
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        raise_pick(52);
        tick();
        rst = 1'b1;
        #2;
        model_reset();
        tests_run++;
        if (board_first_diff() >= 0 || sel_valid !== 1'b0 || turn !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_held: first_diff=%0d sel_valid=%b turn=%b, expected -1/0/0", board_first_diff(), sel_valid, turn);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (move_done !== 1'b0 || sel_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset_held: done=%b sel_valid=%b, expected 0/0", move_done, sel_valid);
        end
        raise_pick(52);
        tick();
        raise_place(36);
        rst = 1'b1;
        #2;
        tests_run++;
        if (board_first_diff() >= 0 || turn !== 1'b0 || move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_commit: first_diff=%0d turn=%b done=%b, expected -1/0/0", board_first_diff(), turn, move_done);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (move_done !== 1'b0 || board_first_diff() >= 0) begin
            tests_failed++;
            $display("FAIL after_reset_commit: done=%b first_diff=%0d, expected 0/-1", move_done, board_first_diff());
        end
    endtask

    task automatic test_random();
        int sq;
        int kind;
        int q [$];
        bit ok;
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            if (!mheld) begin
                q.delete();
                for (int i = 0; i < 64; i++) if (model_pick_ok(i)) q.push_back(i);
                if ($urandom_range(0, 2) != 0 && q.size() > 0)
                    sq = q[$urandom_range(0, q.size() - 1)];
                else
                    sq = int'($urandom_range(0, 63));
                ok = model_pick_ok(sq);
                raise_pick(sq);
                tests_run++;
                if (sel_valid !== ok || move_reject !== !ok || (ok && sel_square !== 6'(sq))) begin
                    tests_failed++;
                    $display("FAIL rand_pick sq=%0d: sel_valid=%b reject=%b sel=%0d, expected %b/%b/%0d", sq, sel_valid, move_reject, sel_square, ok, !ok, sq);
                end
                if (ok) begin
                    mheld = 1'b1;
                    msel  = 6'(sq);
                end
                tick();
            end else begin
                sq = ($urandom_range(0, 7) == 0) ? int'(msel) : int'($urandom_range(0, 63));
                kind = model_place_kind(sq);
                raise_place(sq);
                if (kind == 0) begin
                    mheld = 1'b0;
                    tests_run++;
                    if (sel_valid !== 1'b0 || move_reject !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL rand_cancel sq=%0d: sel_valid=%b reject=%b, expected 0/0", sq, sel_valid, move_reject);
                    end
                end else if (kind == 1) begin
                    tests_run++;
                    if (sel_valid !== 1'b1 || move_reject !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL rand_refuse sq=%0d: sel_valid=%b reject=%b, expected 1/1", sq, sel_valid, move_reject);
                    end
                end else begin
                    tick();
                    model_move(int'(msel), sq);
                    tests_run++;
                    if (move_done !== 1'b1 || turn !== mturn || sel_valid !== 1'b0 || board_first_diff() >= 0) begin
                        tests_failed++;
                        $display("FAIL rand_move to %0d: done=%b turn=%b sel_valid=%b first_diff=%0d, expected 1/%b/0/-1", sq, move_done, turn, sel_valid, board_first_diff(), mturn);
                    end
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_reject_pick();
        test_cancel();
        test_blocked_place();
        test_capture();
        test_back_to_back();
        test_reset_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
